// File: rtl/pwm_gate_driver_pkg.sv
// Shared constants and types for the PWM gate driver.
//   W          : width of the carrier ramp and duty buses
//   RAMP_MIN/MAX: carrier range produced by the ramp generator (900-count period)
//   ST_*       : dead-time FSM state encodings, wrapped by state_e
package pwm_gate_driver_pkg;

    localparam int W = 11;

    localparam logic [W-1:0] RAMP_MIN = 11'd0;
    localparam logic [W-1:0] RAMP_MAX = 11'd899;

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_DT  = 2'd1;
    localparam logic [1:0] ST_HI  = 2'd2;
    localparam logic [1:0] ST_LO  = 2'd3;

    typedef enum logic [1:0] {
        S_OFF = ST_OFF,
        S_DT  = ST_DT,
        S_HI  = ST_HI,
        S_LO  = ST_LO
    } state_e;

endpackage

// File: rtl/pwm_gate_driver_if.sv
// Signal bundle between the controller side (ramp/duty/enable/fault sources)
// and one gate driver instance.
//   master : drives en, fault, ramp_ref, duty_ref; observes the gate outputs
//   slave  : the driver; consumes the commands, drives gate_hi, gate_lo,
//            carrier_sync, fault_lat and the state_dbg observation port
// There is no valid/ready handshake: every input is a level sampled each clk.
interface pwm_gate_driver_if #(
    parameter int W = pwm_gate_driver_pkg::W
);
    logic                        en;
    logic                        fault;
    logic [W-1:0]                ramp_ref;
    logic [W-1:0]                duty_ref;
    logic                        gate_hi;
    logic                        gate_lo;
    logic                        carrier_sync;
    logic                        fault_lat;
    pwm_gate_driver_pkg::state_e state_dbg;

    modport master (
        output en, fault, ramp_ref, duty_ref,
        input  gate_hi, gate_lo, carrier_sync, fault_lat, state_dbg
    );

    modport slave (
        input  en, fault, ramp_ref, duty_ref,
        output gate_hi, gate_lo, carrier_sync, fault_lat, state_dbg
    );

endinterface

// File: rtl/pwm_gate_driver_deadtime_fsm.sv
// Dead-time insertion for one complementary switch pair.
//   clk, rst  : clock, synchronous active-low reset
//   cmp       : registered PWM comparator (1 = high side wanted)
//   kill      : forces OFF on the next edge (fault, latched fault or !en)
//   gate_hi/lo: registered switch commands, never both 1
//   state_dbg : current FSM state for observation
// A gate only asserts after cmp has held the same value for DEADTIME
// consecutive cycles in DT; any change of cmp in DT restarts the count, so
// pulses shorter than the dead-time are swallowed.
module pwm_gate_driver_deadtime_fsm
    import pwm_gate_driver_pkg::*;
#(
    parameter int DEADTIME = 10
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cmp,
    input  logic   kill,
    output logic   gate_hi,
    output logic   gate_lo,
    output state_e state_dbg
);

    localparam logic [7:0] DT_LOAD = 8'(DEADTIME);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       target_q, target_d;
    logic       gate_hi_q, gate_hi_d;
    logic       gate_lo_q, gate_lo_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;

        if (kill) begin
            // Turning off is always safe, so no dead-time wait here.
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d  = S_DT;
                    target_d = cmp;
                    cnt_d    = DT_LOAD;
                end
                S_DT: begin
                    if (cmp != target_q) begin
                        target_d = cmp;
                        cnt_d    = DT_LOAD;
                    end else if (cnt_q == 8'd1) begin
                        state_d = target_q ? S_HI : S_LO;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_HI: begin
                    if (!cmp) begin
                        state_d  = S_DT;
                        target_d = 1'b0;
                        cnt_d    = DT_LOAD;
                    end
                end
                S_LO: begin
                    if (cmp) begin
                        state_d  = S_DT;
                        target_d = 1'b1;
                        cnt_d    = DT_LOAD;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        // Gates follow the next state so they change on the same edge as it.
        gate_hi_d = (state_d == S_HI);
        gate_lo_d = (state_d == S_LO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_OFF;
            cnt_q     <= 8'd0;
            target_q  <= 1'b0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi   = gate_hi_q;
    assign gate_lo   = gate_lo_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/pwm_gate_driver.sv
// Complementary PWM gate driver for one FCML switch pair.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of pwm_gate_driver_if
//              in : en, fault, ramp_ref, duty_ref
//              out: gate_hi, gate_lo, carrier_sync, fault_lat, state_dbg
// The duty command is shadowed and only reloaded when the carrier wraps, so a
// duty change never produces a partial pulse. A fault is latched until reset.
module pwm_gate_driver #(
    parameter int DEADTIME = 10,
    parameter int W        = pwm_gate_driver_pkg::W
) (
    input  logic                    clk,
    input  logic                    rst,
    pwm_gate_driver_if.slave        bus
);
    import pwm_gate_driver_pkg::*;

    logic [W-1:0] ramp_prev_q, ramp_prev_d;
    logic [W-1:0] duty_shadow_q, duty_shadow_d;
    logic         cmp_q, cmp_d;
    logic         carrier_sync_q, carrier_sync_d;
    logic         fault_lat_q, fault_lat_d;
    logic         wrap;
    logic         kill;

    always_comb begin
        // A falling ramp is the only way to see a wrap on a monotonic carrier.
        wrap           = (bus.ramp_ref < ramp_prev_q);
        ramp_prev_d    = bus.ramp_ref;
        carrier_sync_d = wrap;
        duty_shadow_d  = wrap ? bus.duty_ref : duty_shadow_q;
        cmp_d          = (duty_shadow_q > bus.ramp_ref);
        fault_lat_d    = fault_lat_q | bus.fault;
        // The raw fault is included so the gates drop on the sampling edge.
        kill           = bus.fault | fault_lat_q | ~bus.en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ramp_prev_q    <= '0;
            duty_shadow_q  <= '0;
            cmp_q          <= 1'b0;
            carrier_sync_q <= 1'b0;
            fault_lat_q    <= 1'b0;
        end else begin
            ramp_prev_q    <= ramp_prev_d;
            duty_shadow_q  <= duty_shadow_d;
            cmp_q          <= cmp_d;
            carrier_sync_q <= carrier_sync_d;
            fault_lat_q    <= fault_lat_d;
        end
    end

    pwm_gate_driver_deadtime_fsm #(
        .DEADTIME (DEADTIME)
    ) u_deadtime_fsm (
        .clk       (clk),
        .rst       (rst),
        .cmp       (cmp_q),
        .kill      (kill),
        .gate_hi   (bus.gate_hi),
        .gate_lo   (bus.gate_lo),
        .state_dbg (bus.state_dbg)
    );

    assign bus.carrier_sync = carrier_sync_q;
    assign bus.fault_lat    = fault_lat_q;

endmodule

// File: doc/pwm_gate_driver.md
# pwm_gate_driver

- Consumes the 11-bit carrier ramp from the per-phase ramp generator and an 11-bit duty reference on the same scale.
- Produces one complementary gate pair (high/low switch of one FCML cell) with dead-time insertion.
- Duty is double-buffered and updated only at carrier wrap, so pulses are glitch-free.
- A latched fault input forces both switches off.
- One instance per switch pair, downstream of each ramp instance.

## Interface

Parameters:
- DEADTIME, 10: dead-time in clk cycles, legal range 1..255.
- W, 11: width of the ramp and duty buses.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- en  in  1  run enable. 0 forces both gates off; not latched.
- fault  in  1  active-high fault, sampled on clk. Latched until rst.
- ramp_ref  in  W  unsigned carrier from the ramp generator; counts RAMP_MIN..RAMP_MAX, then wraps.
- duty_ref  in  W  unsigned duty command, same scale as ramp_ref.
- gate_hi  out  1  high-side switch command, registered.
- gate_lo  out  1  low-side switch command, registered.
- carrier_sync  out  1  one-cycle pulse on a detected ramp wrap.
- fault_lat  out  1  latched fault status.

## Operation

- Reset values (rst==0 at an edge):
  - gate_hi=0, gate_lo=0, carrier_sync=0, fault_lat=0.
  - duty_shadow=0, ramp_prev=0, cmp=0.
  - state=OFF, cnt=0.
- Wrap detect: wrap = (ramp_ref < ramp_prev); ramp_prev <= ramp_ref every cycle.
  - A wrap is detected on the first sample after the ramp drops from RAMP_MAX to RAMP_MIN.
  - carrier_sync <= wrap.
- Shadow duty: duty_shadow <= duty_ref when wrap==1; otherwise it holds. A duty change mid-period takes effect only after the next wrap.
- Comparator: cmp <= (duty_shadow > ramp_ref), unsigned, full W bits.
  - duty_shadow=0 gives cmp always 0.
  - duty_shadow>RAMP_MAX gives cmp always 1.
- Dead-time FSM, states OFF, DT, HI, LO; 8-bit cnt; 1-bit target:
  - OFF: gates 0. If en && !fault_lat && !fault: go to DT, target<=cmp, cnt<=DEADTIME.
  - DT: gates 0.
    - If cmp!=target: target<=cmp, cnt<=DEADTIME (retarget, full reload).
    - Else if cnt==1: go to HI if target==1, else LO.
    - Else cnt<=cnt-1.
  - HI: gate_hi=1. If cmp==0: go to DT, target<=0, cnt<=DEADTIME.
  - LO: gate_lo=1. If cmp==1: go to DT, target<=1, cnt<=DEADTIME.
- Override priority, highest first: rst, fault, en==0, FSM.
  - fault==1 sampled: state<=OFF, gates<=0, fault_lat<=1, all on that same edge.
  - en==0: state<=OFF, gates<=0.
  - With fault_lat=1 the FSM stays in OFF regardless of en. Only rst clears it.
- Invariant: gate_hi && gate_lo is never 1.
- Between any gate deassert and the opposite gate assert there are at least DEADTIME cycles with both gates 0.
- Pulses shorter than DEADTIME are swallowed by the retarget rule. Neither gate asserts until cmp has been stable for DEADTIME cycles.

## Timing

- ramp_ref sample at edge n changes cmp at edge n+1.
- FSM leaves HI/LO at edge n+2: active gate goes 0.
- Opposite gate asserts at edge n+2+DEADTIME.
- Wrap: the ramp falls at edge m. wrap is combinational in cycle m. carrier_sync=1 and duty_shadow are updated at edge m+1.
- New duty affects cmp from edge m+2.
- Fault and en response: one edge, with no dead-time wait, since turning off is always safe.
- After en rises from OFF: first gate assertion DEADTIME+1 edges later (OFF→DT, then DEADTIME cycles).
- Reset mid-pulse: gates 0 at the reset edge. After release the sequence restarts from OFF with duty_shadow=0, so the first gate is LO until the first wrap.

## Structure

- Shared package / param include holds:
  - RAMP_MIN=0 and RAMP_MAX=899 (same constants as the ramp generator, 900-count period).
  - W=11.
  - State encoding localparams for OFF/DT/HI/LO.
- Natural sub-module: deadtime_fsm.
  - Inputs: clk, rst, cmp, kill = fault|fault_lat|!en.
  - Outputs: gate_hi, gate_lo.
  - Parameter: DEADTIME.
- Top-level keeps wrap detect, shadow register, comparator and fault latch.

## Test plan

1. Steady PWM, DEADTIME=10, duty_ref=450, free-running ramp 0..899:
   - gate_hi high 450−10=440 cycles per period, gate_lo 450−10=440.
   - Exactly 10 both-off cycles at each of the two transitions.
   - carrier_sync pulses every 900 cycles.
2. Shadow update: change duty_ref 450→600 at ramp=200.
   - Current period keeps the 450 edge.
   - From the period after the next carrier_sync, gate_hi falls at ramp≈600+2 cycles.
3. Narrow pulse: duty_ref=5, DEADTIME=10.
   - cmp is high for 5 cycles, so gate_hi never asserts; the retarget rule fires.
   - gate_lo returns 10 cycles after cmp falls.
   - gate_hi&&gate_lo never both 1 (assertion throughout).
4. Fault: assert fault for 1 cycle while gate_hi=1.
   - Both gates 0 at the next edge; fault_lat=1.
   - Toggling en leaves gates at 0; rst pulse clears fault_lat and gates resume DEADTIME+1 cycles after en.
5. Extremes:
   - duty_ref=0: gate_lo continuous after start-up, gate_hi never asserts.
   - duty_ref=1000: gate_hi continuous.
   - en deassert mid-DT: state returns to OFF and both gates stay 0.
